// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller beside the ID/EX boundary: in-flight rd scoreboard, registered forwarding
// selects, load-use bubbles and redirect kill. Perf counters are built only when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int  REG_AW      = 5,
    parameter int  FWD_DEPTH   = 3,
    parameter int  LOAD_LAT    = 1,
    parameter int  FLUSH_SLOTS = 2,
    parameter int  CNT_W       = 32,
    localparam int FW          = $clog2(FWD_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_load_i,
    input  logic              redirect_i,
    output logic              stall_o,
    output logic              flush_id_o,
    output logic              bubble_ex_o,
    output logic [FW-1:0]     fwd_a_o,
    output logic [FW-1:0]     fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  fwd_cnt_o
);

    // The last slot (WB) never forwards because the register file is write-first,
    // so only slots 1..FWD_DEPTH-1 need storage.
    localparam int NS = FWD_DEPTH - 1;

    logic [NS:1]       r_vld;
    logic [NS:1]       r_ld;
    logic [REG_AW-1:0] r_rd [1:NS];
    logic [FW-1:0]     r_fwd_a;
    logic [FW-1:0]     r_fwd_b;

    logic [FW-1:0]     w_ka;
    logic [FW-1:0]     w_kb;
    logic              w_lu_a;
    logic              w_lu_b;
    logic              w_load_use;
    logic              w_redirect;
    logic              w_bubble;

    // Oldest-to-youngest walk so the youngest match is the last one written.
    always_comb begin
        w_ka   = '0;
        w_kb   = '0;
        w_lu_a = 1'b0;
        w_lu_b = 1'b0;
        for (int k = NS; k >= 1; k--) begin
            if (r_vld[k] && (id_rs1_i != '0) && (r_rd[k] == id_rs1_i)) begin
                w_ka   = FW'(k);
                w_lu_a = r_ld[k] && (k <= LOAD_LAT);
            end
            if (r_vld[k] && (id_rs2_i != '0) && (r_rd[k] == id_rs2_i)) begin
                w_kb   = FW'(k);
                w_lu_b = r_ld[k] && (k <= LOAD_LAT);
            end
        end
    end

    assign w_redirect  = redirect_i & rst_ni;
    assign w_load_use  = id_valid_i & (w_lu_a | w_lu_b);
    assign w_bubble    = w_load_use | w_redirect;

    assign stall_o     = w_load_use & ~w_redirect;
    assign flush_id_o  = w_redirect;
    assign bubble_ex_o = w_bubble;
    assign fwd_a_o     = r_fwd_a;
    assign fwd_b_o     = r_fwd_b;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld   <= '0;
            r_ld    <= '0;
            r_fwd_a <= '0;
            r_fwd_b <= '0;
            for (int k = 1; k <= NS; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            // A redirect kills the instructions younger than the resolving branch as they shift.
            for (int k = NS; k >= 2; k--) begin
                r_vld[k] <= r_vld[k-1] & ~(w_redirect & ((k - 1) < FLUSH_SLOTS));
                r_rd[k]  <= r_rd[k-1];
                r_ld[k]  <= r_ld[k-1];
            end
            r_vld[1] <= id_valid_i & id_regwrite_i & (id_rd_i != '0) & ~w_bubble;
            r_rd[1]  <= id_rd_i;
            r_ld[1]  <= id_load_i;

            if (w_bubble || !id_valid_i) begin
                r_fwd_a <= '0;
                r_fwd_b <= '0;
            end else begin
                r_fwd_a <= w_ka;
                r_fwd_b <= w_kb;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_fwd_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stall_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (((r_fwd_a != '0) || (r_fwd_b != '0)) && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign fwd_cnt_o   = r_fwd_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
    assign fwd_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: default instance plus a FWD_DEPTH=4 / LOAD_LAT=2 instance,
// both checked every cycle against an instruction-history model, plus literal expectations.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] rs1      = 5'd0;
    logic [4:0] rs2      = 5'd0;
    logic [4:0] rd       = 5'd0;
    logic       rw       = 1'b0;
    logic       ld       = 1'b0;
    logic       redirect = 1'b0;

    logic        stall0, flush0, bub0, stall1, flush1, bub1;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [31:0] cs0, cf0, cw0, cs1, cf1, cw1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rd_i(rd), .id_regwrite_i(rw), .id_load_i(ld), .redirect_i(redirect),
        .stall_o(stall0), .flush_id_o(flush0), .bubble_ex_o(bub0), .fwd_a_o(fa0), .fwd_b_o(fb0),
        .stall_cnt_o(cs0), .flush_cnt_o(cf0), .fwd_cnt_o(cw0)
    );

    pipe_hazard_ctrl #(.FWD_DEPTH(4), .LOAD_LAT(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rd_i(rd), .id_regwrite_i(rw), .id_load_i(ld), .redirect_i(redirect),
        .stall_o(stall1), .flush_id_o(flush1), .bubble_ex_o(bub1), .fwd_a_o(fa1), .fwd_b_o(fb1),
        .stall_cnt_o(cs1), .flush_cnt_o(cf1), .fwd_cnt_o(cw1)
    );

    function automatic int dep(input int i); return (i == 0) ? 3 : 4; endfunction
    function automatic int lat(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int fl(input int i);  return 2; endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // Model: log of accepted writers per instance, with the cycle they entered EX.
    typedef struct {
        int         inst;
        logic [4:0] rd;
        bit         ld;
        int         cyc;
    } rec_t;

    rec_t      log_q[$];
    int        ncyc;
    bit        m_stall [2];
    bit        m_bub   [2];
    bit [1:0]  m_fa    [2];
    bit [1:0]  m_fb    [2];
    bit [1:0]  m_nfa   [2];
    bit [1:0]  m_nfb   [2];
    bit [31:0] m_cs    [2];
    bit [31:0] m_cf    [2];
    bit [31:0] m_cw    [2];

    function automatic int youngest(input int inst, input logic [4:0] rs, output bit is_ld);
        int best;
        int age;
        best  = 0;
        is_ld = 1'b0;
        if (rs == 5'd0) return 0;
        foreach (log_q[n]) begin
            age = ncyc - log_q[n].cyc;
            if (log_q[n].inst == inst && log_q[n].rd == rs && age >= 1 && age <= dep(inst) - 1 &&
                (best == 0 || age < best)) begin
                best  = age;
                is_ld = log_q[n].ld;
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int ka, kb;
            bit la, lb, lu;
            ka = 0; kb = 0; la = 0; lb = 0; lu = 0;
            if (!rst_n) begin
                m_stall[i] = 1'b0;
                m_bub[i]   = 1'b0;
                m_nfa[i]   = 2'd0;
                m_nfb[i]   = 2'd0;
            end else begin
                ka = youngest(i, rs1, la);
                kb = youngest(i, rs2, lb);
                lu = id_valid && ((ka != 0 && la && ka <= lat(i)) || (kb != 0 && lb && kb <= lat(i)));
                m_stall[i] = lu && !redirect;
                m_bub[i]   = lu || redirect;
                m_nfa[i]   = (id_valid && !m_bub[i]) ? 2'(ka) : 2'd0;
                m_nfb[i]   = (id_valid && !m_bub[i]) ? 2'(kb) : 2'd0;
            end
            chk("stall",  i, (i == 0) ? stall0 : stall1, m_stall[i]);
            chk("flush",  i, (i == 0) ? flush0 : flush1, rst_n ? redirect : 1'b0);
            chk("bubble", i, (i == 0) ? bub0 : bub1, m_bub[i]);
            chk("fwd_a",  i, (i == 0) ? fa0 : fa1, m_fa[i]);
            chk("fwd_b",  i, (i == 0) ? fb0 : fb1, m_fb[i]);
            chk("stall_cnt", i, (i == 0) ? cs0 : cs1, PERF ? m_cs[i] : 32'd0);
            chk("flush_cnt", i, (i == 0) ? cf0 : cf1, PERF ? m_cf[i] : 32'd0);
            chk("fwd_cnt",   i, (i == 0) ? cw0 : cw1, PERF ? m_cw[i] : 32'd0);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_q.delete();
            ncyc = 0;
            for (int i = 0; i < 2; i++) begin
                m_fa[i] = 2'd0; m_fb[i] = 2'd0;
                m_cs[i] = 32'd0; m_cf[i] = 32'd0; m_cw[i] = 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_stall[i]) m_cs[i] = m_cs[i] + 32'd1;
                if (redirect) m_cf[i] = m_cf[i] + 32'd1;
                if (m_fa[i] != 0 || m_fb[i] != 0) m_cw[i] = m_cw[i] + 32'd1;
                m_fa[i] = m_nfa[i];
                m_fb[i] = m_nfb[i];
            end
            for (int n = log_q.size() - 1; n >= 0; n--) begin
                int age;
                age = ncyc - log_q[n].cyc;
                if ((redirect && age < fl(log_q[n].inst)) || age + 1 >= dep(log_q[n].inst))
                    log_q.delete(n);
            end
            for (int i = 0; i < 2; i++) begin
                if (id_valid && rw && rd != 5'd0 && !m_bub[i])
                    log_q.push_back('{i, rd, ld, ncyc});
            end
            ncyc++;
        end
    end

    task automatic put(input bit v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input bit w, input bit l, input bit r);
        @(posedge clk);
        #1;
        id_valid = v; rs1 = a; rs2 = b; rd = d; rw = w; ld = l; redirect = r;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) put(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", 0, stall0, 0);
        chk("rst_bubble", 0, bub0, 0);
        chk("rst_fwd_a", 0, fa0, 0);
        chk("rst_stall_cnt", 0, cs0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        // back-to-back ALU producer/consumer
        put(1, 5'd0, 5'd0, 5'd5, 1, 0, 0);
        put(1, 5'd5, 5'd1, 5'd6, 1, 0, 0);
        chk("alu_nostall", 0, stall0, 0);
        idle(1);
        chk("alu_fwd_a1", 0, fa0, 1);
        chk("alu_fwd_b0", 0, fb0, 0);
        chk("alu_fwd_a1", 1, fa1, 1);
        idle(4);

        // one gap
        put(1, 5'd0, 5'd0, 5'd5, 1, 0, 0);
        put(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        put(1, 5'd5, 5'd0, 5'd7, 1, 0, 0);
        idle(1);
        chk("gap1_fwd_a", 0, fa0, 2);
        chk("gap1_fwd_a", 1, fa1, 2);
        idle(4);

        // two gaps: WB slot ignored at depth 3, still forwarded at depth 4
        put(1, 5'd0, 5'd0, 5'd5, 1, 0, 0);
        put(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        put(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        put(1, 5'd5, 5'd0, 5'd7, 1, 0, 0);
        idle(1);
        chk("gap2_fwd_a", 0, fa0, 0);
        chk("gap2_fwd_a", 1, fa1, 3);
        idle(4);

        // load-use: one stall cycle at LOAD_LAT=1, two at LOAD_LAT=2
        put(1, 5'd0, 5'd0, 5'd5, 1, 1, 0);
        put(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
        chk("lu_stall_c1", 0, stall0, 1);
        chk("lu_bubble_c1", 0, bub0, 1);
        chk("lu_stall_c1", 1, stall1, 1);
        put(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
        chk("lu_stall_c2", 0, stall0, 0);
        chk("lu_stall_c2", 1, stall1, 1);
        chk("lu_fwd_bubble", 0, fa0, 0);
        put(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
        chk("lu_fwd_a2", 0, fa0, 2);
        chk("lu_fwd_b2", 0, fb0, 2);
        chk("lu_stall_c3", 1, stall1, 0);
        idle(1);
        chk("lu_fwd_a3", 1, fa1, 3);
        chk("lu_fwd_a_wb", 0, fa0, 0);
        idle(5);

        // x0 is never a hazard
        put(1, 5'd0, 5'd0, 5'd0, 1, 1, 0);
        put(1, 5'd0, 5'd0, 5'd8, 1, 0, 0);
        chk("x0_nostall", 0, stall0, 0);
        chk("x0_nostall", 1, stall1, 0);
        idle(1);
        chk("x0_fwd_a", 0, fa0, 0);
        chk("x0_fwd_b", 0, fb0, 0);
        idle(4);

        // redirect overrides load-use and kills the load
        put(1, 5'd0, 5'd0, 5'd5, 1, 1, 0);
        put(1, 5'd5, 5'd0, 5'd6, 1, 0, 1);
        chk("rd_stall", 0, stall0, 0);
        chk("rd_flush", 0, flush0, 1);
        chk("rd_bubble", 0, bub0, 1);
        chk("rd_stall", 1, stall1, 0);
        put(1, 5'd5, 5'd0, 5'd7, 1, 0, 0);
        chk("rd_after_stall", 0, stall0, 0);
        chk("rd_after_stall", 1, stall1, 0);
        idle(1);
        chk("rd_after_fwd", 0, fa0, 0);
        chk("rd_after_fwd", 1, fa1, 0);
        put(1, 5'd0, 5'd0, 5'd9, 1, 0, 1);
        chk("rd2_flush_a", 0, flush0, 1);
        put(1, 5'd9, 5'd0, 5'd10, 1, 0, 1);
        chk("rd2_flush_b", 0, flush0, 1);
        put(1, 5'd9, 5'd0, 5'd11, 1, 0, 0);
        chk("rd2_flush_clr", 0, flush0, 0);
        idle(1);
        chk("rd2_fwd", 0, fa0, 0);
        idle(4);

        // reset during a stall
        put(1, 5'd0, 5'd0, 5'd5, 1, 1, 0);
        put(1, 5'd5, 5'd0, 5'd6, 1, 0, 0);
        chk("rs_pre_stall", 0, stall0, 1);
        chk("rs_pre_stall", 1, stall1, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_stall", 0, stall0, 0);
        chk("rs_bubble", 0, bub0, 0);
        chk("rs_stall", 1, stall1, 0);
        chk("rs_fwd_a", 0, fa0, 0);
        chk("rs_stall_cnt", 0, cs0, 0);
        chk("rs_fwd_cnt", 1, cw1, 0);
        redirect = 1'b1;
        #2;
        chk("rs_flush_gated", 0, flush0, 0);
        chk("rs_bubble_gated", 0, bub0, 0);
        redirect = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rs_no_resume", 0, stall0, 0);
        chk("rs_no_resume", 1, stall1, 0);
        put(1, 5'd5, 5'd0, 5'd6, 1, 0, 0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard controller for the pipelined RISC-V core. Tracks in-flight destination registers in a shift-register scoreboard, produces registered forwarding selects for both EX operands, inserts load-use bubbles, and kills younger instructions on a control-flow redirect. It sits beside the ID/EX boundary and replaces the purely combinational forwarding unit. Depth, load latency and flush width are generic.

## Interface
- REG_AW, 5: register address width.
- FWD_DEPTH, 3: tracked slots after ID (slot 1 = EX, 2 = MEM, 3 = WB); minimum 2.
- LOAD_LAT, 1: distance at or below which a load result cannot yet be forwarded; range 1..FWD_DEPTH-1.
- FLUSH_SLOTS, 2: younger instructions killed by a redirect (ID plus slots 1..FLUSH_SLOTS-1); range 1..FWD_DEPTH.
- CNT_W, 32: perf counter width.
- FW, derived, $clog2(FWD_DEPTH): forward-select width.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  instruction present in ID.
- id_rs1_i, id_rs2_i  in  REG_AW  ID source registers.
- id_rd_i  in  REG_AW  ID destination.
- id_regwrite_i  in  1  ID instruction writes rd.
- id_load_i  in  1  ID instruction is a load.
- redirect_i  in  1  taken branch/jump resolved this cycle.
- stall_o  out  1  hold PC and IF/ID register.
- flush_id_o  out  1  squash IF/ID contents.
- bubble_ex_o  out  1  load NOP into ID/EX.
- fwd_a_o, fwd_b_o  out  FW  EX operand source: 0 = register file, k = producer k stages ahead of EX.
- stall_cnt_o, flush_cnt_o, fwd_cnt_o  out  CNT_W  perf counters.

## Operation
- Scoreboard: FWD_DEPTH slots {valid, rd, load}. Every cycle slot k+1 <= slot k; last slot drops out. Slot 1 <= ID entry (valid = id_valid_i & id_regwrite_i & rd != 0), or invalid when bubbling.
- Match: slot k matches rsX when valid and rd == rsX; rsX == 0 never matches. Youngest (lowest k) match wins. Matches in slot FWD_DEPTH are ignored (register file is write-first).
- Load-use: youngest match for either operand is a load in slot k <= LOAD_LAT and id_valid_i -> stall_o = 1, bubble_ex_o = 1; combinational, same cycle. Re-evaluated each cycle; stall persists until the load has advanced past LOAD_LAT.
- Forwarding: with no stall/redirect, fwd_a_o/fwd_b_o <= k of youngest match (else 0), registered so they are valid while the instruction is in EX. On bubble or flush, both <= 0.
- Redirect: redirect_i = 1 -> flush_id_o = 1, bubble_ex_o = 1, slots 1..FLUSH_SLOTS-1 invalidated on the same shift. Redirect overrides stall: stall_o = 0 that cycle.

## Timing
- Reset: all slots invalid, fwd_a_o = fwd_b_o = 0, counters 0; combinational outputs therefore 0.
- stall_o, flush_id_o, bubble_ex_o: zero-latency from inputs and current slots.
- fwd_*: one-cycle latency, aligned with the ID/EX register.
- Reset asserted mid-stall: outputs drop to 0 immediately; no stall resumes after release.
- Back-to-back redirects: each kills independently; no internal counter.
- id_valid_i = 0: no stall, slot 1 invalid, fwd 0.

## Configuration
- HAZARD_PERF_EN defined: stall_cnt_o +1 per stall cycle, flush_cnt_o +1 per redirect cycle, fwd_cnt_o +1 per cycle with any nonzero registered fwd select; all saturate at 2^CNT_W-1.
- Undefined: counters not built; ports remain, tied to 0.

## Test plan
- add x5 then add x6,x5,x1 back-to-back -> no stall; next cycle fwd_a_o = 1; one gap instruction -> fwd_a_o = 2; two gaps -> 0.
- lw x5 then add x6,x5,x5 (LOAD_LAT = 1) -> stall_o = 1 and bubble_ex_o = 1 for exactly one cycle, then fwd_a_o = fwd_b_o = 2.
- Write to x0 followed by reader of x0 -> no stall, fwd 0.
- Redirect coinciding with load-use stall -> stall_o = 0, flush_id_o = 1, slot 1 invalid; following reader of the load's rd gets fwd 0.
- Reset asserted during stall -> all outputs 0 within the same cycle; HAZARD_PERF_EN counters read 0; with LOAD_LAT = 2, FWD_DEPTH = 4 -> load-use stall lasts two cycles.
